// File: rtl/limbus_st_timing_adaptor_gen2.sv
`default_nettype none
// ============================================================================
// Module      : limbus_st_timing_adaptor_gen2
// Description : Avalon-ST timing adapter that bridges a source with ready latency
//               IN_READY_LATENCY to a ready-latency-0 sink through a show-ahead
//               FIFO. Optional sticky underrun flag via macro ST_TA_UNDERRUN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module limbus_st_timing_adaptor_gen2 #(
    parameter int DATA_W           = 32,
    parameter int DEPTH            = 16,
    parameter int IN_READY_LATENCY = 0,
    parameter int AFULL_DEFAULT    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic [$clog2(DEPTH):0]   afull_thr,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow,
    input  logic                     err_clr
`ifdef ST_TA_UNDERRUN_EN
    ,
    output logic                     underrun
`endif
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_FILL_W = c_ADDR_W + 1;

    localparam logic [c_FILL_W-1:0] c_DEPTH         = c_FILL_W'(DEPTH);
    localparam logic [c_FILL_W-1:0] c_RDY_MAX       = c_FILL_W'(DEPTH - 1 - IN_READY_LATENCY);
    localparam logic [c_FILL_W-1:0] c_AFULL_DEFAULT = c_FILL_W'(AFULL_DEFAULT);
    localparam logic [c_FILL_W-1:0] c_FILL_ONE      = c_FILL_W'(1);
    localparam logic [c_FILL_W-1:0] c_FILL_ZERO     = '0;
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE       = c_ADDR_W'(1);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_FILL_W-1:0] r_afull_thr;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_in_ready;
    logic                r_afull;
    logic                r_overflow;

    logic                w_wr_req;
    logic                w_pop;
    logic                w_full;
    logic                w_push;
    logic                w_ovf_evt;
    logic                w_head_bypass;
    logic [c_FILL_W-1:0] w_fill_next;
    logic [c_ADDR_W-1:0] w_rd_ptr_next;
    logic [DATA_W-1:0]   w_head_next;

    // With a non-zero latency the source owns the contract, so every valid beat
    // is a write attempt; in_ready only gates beats when the latency is zero.
    generate
        if (IN_READY_LATENCY == 0) begin : g_lat_zero
            assign w_wr_req = in_valid & r_in_ready;
        end else begin : g_lat_nonzero
            assign w_wr_req = in_valid;
        end
    endgenerate

    assign w_pop     = r_out_valid & out_ready;
    assign w_full    = (r_fill == c_DEPTH);
    assign w_push    = w_wr_req & (~w_full | w_pop);
    assign w_ovf_evt = w_wr_req & w_full & ~w_pop;

    always_comb begin
        w_fill_next = r_fill;
        if (w_push && !w_pop) begin
            w_fill_next = r_fill + c_FILL_ONE;
        end else if (!w_push && w_pop) begin
            w_fill_next = r_fill - c_FILL_ONE;
        end
    end

    assign w_rd_ptr_next = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

    // When the FIFO drains to empty this cycle the incoming beat becomes the
    // new head directly; its storage slot is only written at this same edge.
    assign w_head_bypass = (r_fill == (w_pop ? c_FILL_ONE : c_FILL_ZERO));
    assign w_head_next   = w_head_bypass ? in_data : r_mem[w_rd_ptr_next];

    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_in_ready  <= 1'b0;
            r_afull     <= 1'b0;
            r_afull_thr <= c_AFULL_DEFAULT;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_rd_ptr    <= w_rd_ptr_next;
            r_fill      <= w_fill_next;
            r_out_valid <= (w_fill_next != c_FILL_ZERO);
            if (w_fill_next != c_FILL_ZERO) begin
                r_out_data <= w_head_next;
            end
            r_in_ready  <= (w_fill_next <= c_RDY_MAX);
            r_afull_thr <= afull_thr;
            r_afull     <= (w_fill_next >= r_afull_thr);
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign almost_full = r_afull;
    assign fill_level  = r_fill;
    assign overflow    = r_overflow;

`ifdef ST_TA_UNDERRUN_EN
    logic r_popped;
    logic r_underrun;

    // Starvation only counts once the stream has actually started delivering.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_popped   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_pop) begin
                r_popped <= 1'b1;
            end else if (err_clr) begin
                r_popped <= 1'b0;
            end
            if (out_ready && !r_out_valid && r_popped) begin
                r_underrun <= 1'b1;
            end else if (err_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign underrun = r_underrun;
`else
    // Pop history is not tracked when underrun detection is not built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_limbus_st_timing_adaptor_gen2.sv
`default_nettype none
// ============================================================================
// Module      : tb_limbus_st_timing_adaptor_gen2
// Description : Self-checking bench for two adapter configurations (depth 16 /
//               latency 0 and depth 8 / latency 2) against a queue-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_limbus_st_timing_adaptor_gen2;

    localparam int DW  = 32;
    localparam int D0  = 16;
    localparam int L0  = 0;
    localparam int AF0 = 12;
    localparam int D1  = 8;
    localparam int L1  = 2;
    localparam int AF1 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0, iv0, or0, clr0, ir0, ov0, af0, of0;
    logic [DW-1:0] id0, od0;
    logic [4:0]    thr0, fl0;
    logic          rst1, iv1, or1, clr1, ir1, ov1, af1, of1;
    logic [DW-1:0] id1, od1;
    logic [3:0]    thr1, fl1;
`ifdef ST_TA_UNDERRUN_EN
    logic          ur0, ur1;
`endif

    limbus_st_timing_adaptor_gen2 #(
        .DATA_W(DW), .DEPTH(D0), .IN_READY_LATENCY(L0), .AFULL_DEFAULT(AF0)
    ) u_dut0 (
        .clk(clk), .reset(rst0), .in_ready(ir0), .in_valid(iv0), .in_data(id0),
        .out_ready(or0), .out_valid(ov0), .out_data(od0), .afull_thr(thr0),
        .almost_full(af0), .fill_level(fl0), .overflow(of0), .err_clr(clr0)
`ifdef ST_TA_UNDERRUN_EN
        , .underrun(ur0)
`endif
    );

    limbus_st_timing_adaptor_gen2 #(
        .DATA_W(DW), .DEPTH(D1), .IN_READY_LATENCY(L1), .AFULL_DEFAULT(AF1)
    ) u_dut1 (
        .clk(clk), .reset(rst1), .in_ready(ir1), .in_valid(iv1), .in_data(id1),
        .out_ready(or1), .out_valid(ov1), .out_data(od1), .afull_thr(thr1),
        .almost_full(af1), .fill_level(fl1), .overflow(of1), .err_clr(clr1)
`ifdef ST_TA_UNDERRUN_EN
        , .underrun(ur1)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: circular queue with occupancy count per instance.
    int            m_depth [2] = '{D0, D1};
    int            m_lat   [2] = '{L0, L1};
    int            m_afdef [2] = '{AF0, AF1};
    logic [DW-1:0] m_buf   [2][16];
    int            m_head  [2];
    int            m_cnt   [2];
    bit            m_ir    [2];
    bit            m_af    [2];
    bit            m_afv   [2];
    int            m_thr_last [2];
    bit            m_of    [2];
    bit            m_pp    [2];
    bit            m_ur    [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit iv, input bit ordy,
                              input bit clr, input logic [DW-1:0] d, input int thr);
        bit pop, wr, ovf, ur_evt;
        if (rst) begin
            m_cnt[i] = 0; m_head[i] = 0; m_ir[i] = 0; m_af[i] = 0; m_afv[i] = 1;
            m_of[i] = 0; m_pp[i] = 0; m_ur[i] = 0; m_thr_last[i] = m_afdef[i];
        end else begin
            pop    = (m_cnt[i] > 0) && ordy;
            wr     = (m_lat[i] == 0) ? (iv && m_ir[i]) : iv;
            ur_evt = ordy && (m_cnt[i] == 0) && m_pp[i];
            ovf    = 0;
            if (pop) begin
                m_head[i] = (m_head[i] + 1) % m_depth[i];
                m_cnt[i]--;
            end
            if (wr) begin
                if (m_cnt[i] == m_depth[i]) ovf = 1;
                else begin
                    m_buf[i][(m_head[i] + m_cnt[i]) % m_depth[i]] = d;
                    m_cnt[i]++;
                end
            end
            m_of[i] = ovf ? 1'b1 : (clr ? 1'b0 : m_of[i]);
            m_ur[i] = ur_evt ? 1'b1 : (clr ? 1'b0 : m_ur[i]);
            m_pp[i] = pop ? 1'b1 : (clr ? 1'b0 : m_pp[i]);
            m_ir[i] = (m_cnt[i] <= m_depth[i] - 1 - m_lat[i]);
            m_af[i] = (m_cnt[i] >= thr);
            // A freshly changed watermark is allowed one cycle to take effect.
            m_afv[i] = (thr == m_thr_last[i]);
            m_thr_last[i] = thr;
        end
    endtask

    task automatic check_outputs;
        chk("ir0", ir0, m_ir[0]);
        chk("ov0", ov0, m_cnt[0] != 0);
        chk("fl0", fl0, m_cnt[0]);
        chk("of0", of0, m_of[0]);
        if (m_cnt[0] != 0) chk("od0", od0, m_buf[0][m_head[0]]);
        if (m_afv[0]) chk("af0", af0, m_af[0]);
        chk("ir1", ir1, m_ir[1]);
        chk("ov1", ov1, m_cnt[1] != 0);
        chk("fl1", fl1, m_cnt[1]);
        chk("of1", of1, m_of[1]);
        if (m_cnt[1] != 0) chk("od1", od1, m_buf[1][m_head[1]]);
        if (m_afv[1]) chk("af1", af1, m_af[1]);
`ifdef ST_TA_UNDERRUN_EN
        chk("ur0", ur0, m_ur[0]);
        chk("ur1", ur1, m_ur[1]);
`endif
    endtask

    task automatic tick;
        model_step(0, rst0, iv0, or0, clr0, id0, int'(thr0));
        model_step(1, rst1, iv1, or1, clr1, id1, int'(thr1));
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic fill_inst1(input int extra);
        int n;
        n = 0;
        iv1 = 1'b1;
        while (ir1 && n < 20) begin
            id1 = $urandom;
            tick();
            n++;
        end
        chk("ir1_fall_beats", n, 6);
        for (int k = 0; k < extra; k++) begin
            id1 = $urandom;
            tick();
        end
        iv1 = 1'b0;
    endtask

    initial begin
        rst0 = 1; iv0 = 0; or0 = 0; clr0 = 0; id0 = '0; thr0 = 5'(AF0);
        rst1 = 1; iv1 = 0; or1 = 0; clr1 = 0; id1 = '0; thr1 = 4'(AF1);
        repeat (3) tick();
        chk("rst_ir0", ir0, 0);
        chk("rst_od0", od0, 0);
        chk("rst_af0", af0, 0);
        chk("rst_fl1", fl1, 0);
        chk("rst_ov1", ov1, 0);
        rst0 = 0; rst1 = 0;
        tick();
        chk("ir0_rise", ir0, 1);
        chk("ir1_rise", ir1, 1);

        // Fill depth-16 instance with 0..15, no reads.
        iv0 = 1;
        for (int k = 0; k < 16; k++) begin
            id0 = DW'(k);
            tick();
            if (k == 10) chk("af0_fill11", af0, 0);
            if (k == 11) chk("af0_fill12", af0, 1);
        end
        iv0 = 0;
        chk("fl0_full", fl0, 16);
        chk("ir0_full", ir0, 0);
        chk("af0_full", af0, 1);

        // Drain in order.
        or0 = 1;
        for (int k = 0; k < 16; k++) begin
            chk("drain_od0", od0, k);
            tick();
        end
        chk("drain_ov0", ov0, 0);
        chk("drain_fl0", fl0, 0);
        or0 = 0;

        // Latency 2: two beats after in_ready falls are stored.
        fill_inst1(2);
        chk("l2_fl_after2", fl1, 8);
        chk("l2_of_after2", of1, 0);

        // Latency 2: a third late beat is dropped.
        rst1 = 1; tick(); rst1 = 0; tick();
        fill_inst1(3);
        chk("l2_fl_after3", fl1, 8);
        chk("l2_of_after3", of1, 1);
        clr1 = 1; tick(); clr1 = 0;
        chk("l2_of_cleared", of1, 0);
        iv1 = 1; clr1 = 1; id1 = $urandom; tick(); iv1 = 0; clr1 = 0;
        chk("l2_of_clr_and_set", of1, 1);
        clr1 = 1; tick(); clr1 = 0;
        chk("l2_of_clr2", of1, 0);

        // Streaming through a full FIFO.
        iv1 = 1; or1 = 1;
        for (int k = 0; k < 100; k++) begin
            id1 = $urandom;
            tick();
        end
        iv1 = 0; or1 = 0;
        chk("stream_fl1", fl1, 8);
        chk("stream_of1", of1, 0);

        // Reset mid-operation discards contents.
        iv0 = 1;
        repeat (5) begin id0 = $urandom; tick(); end
        iv0 = 0;
        chk("pre_rst_fl0", fl0, 5);
        rst0 = 1; tick();
        chk("rst_mid_ov0", ov0, 0);
        chk("rst_mid_fl0", fl0, 0);
        rst0 = 0; tick(); tick();
        chk("post_rst_ov0", ov0, 0);

        // Watermark boundaries.
        thr0 = 5'd0; tick(); tick();
        chk("thr0_zero", af0, 1);
        iv0 = 1;
        repeat (16) begin id0 = $urandom; tick(); end
        iv0 = 0;
        thr0 = 5'd17; tick(); tick();
        chk("thr_above_depth", af0, 0);
        chk("thr_above_fl0", fl0, 16);
        thr0 = 5'd16; tick(); tick();
        chk("thr_eq_depth", af0, 1);
        or0 = 1;
        repeat (18) tick();
`ifdef ST_TA_UNDERRUN_EN
        chk("underrun_set", ur0, 1);
        clr0 = 1; tick(); clr0 = 0; tick();
        chk("underrun_clr", ur0, 0);
`endif
        or0 = 0;
        thr0 = 5'(AF0); tick(); tick();

        // Randomised traffic on both instances.
        for (int c = 0; c < 3000; c++) begin
            iv0  = ($urandom % 4) != 0;
            or0  = ($urandom % 3) != 0;
            id0  = $urandom;
            clr0 = ($urandom % 50) == 0;
            rst0 = ($urandom % 400) == 0;
            iv1  = ($urandom % 3) != 0;
            or1  = ($urandom % 2) != 0;
            id1  = $urandom;
            clr1 = ($urandom % 50) == 0;
            rst1 = ($urandom % 400) == 0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
